// File: rtl/simple_uart_pkg.sv
// Shared UART definitions: receiver/transmitter state set, frame width and default bit timing.
package simple_uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a configurable reset level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/simple_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, registered outputs, stop-bit errors park in BREAK until the line idles.
module simple_uart_rx
    import simple_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 line,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MID  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 rx;
    uart_state_t          state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 valid_n, frame_err_n, busy_n;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (line),
        .q     (rx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= frame_err_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        data_n      = data;
        valid_n     = 1'b0;
        frame_err_n = 1'b0;

        case (state)
            IDLE: begin
                if (!rx) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == CNT_MID) begin
                    cnt_n = '0;
                    if (!rx) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx, shreg[DATA_BITS-1:1]};
                    if (bit_idx == BIT_LAST) begin
                        state_n   = STOP;
                        bit_idx_n = '0;
                    end else begin
                        bit_idx_n = bit_idx + BW'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                // Leaving at mid-stop lets a start bit that follows with no gap be caught from IDLE.
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (rx) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = BREAK;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            BREAK: begin
                if (rx) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_simple_uart_rx.sv
// Self-checking bench for simple_uart_rx: directed table, corner sequences and a random loopback against a frame-level model.
`timescale 1ns/1ps
module tb_simple_uart_rx;

    localparam int CPB     = 16;
    localparam int LAT_MAX = 9 * CPB + CPB / 2 + 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, busy;

    simple_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line      (line),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int last_valid_cyc = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    bit overlap_seen = 0, long_valid = 0, long_ferr = 0, busy_at_valid = 0;
    bit prev_valid = 0, prev_ferr = 0;
    logic [7:0] rx_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            rx_q.push_back(data);
            last_valid_cyc = cyc;
            if (busy) busy_at_valid = 1;
        end
        if (frame_err) ferr_cnt++;
        if (valid && frame_err) overlap_seen = 1;
        if (valid && prev_valid) long_valid = 1;
        if (frame_err && prev_ferr) long_ferr = 1;
        prev_valid = valid;
        prev_ferr  = frame_err;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_le(input string name, input int got, input int lim);
        tests++;
        if (got > lim) begin
            fails++;
            $display("FAIL %s: got %0d, expected <= %0d", name, got, lim);
        end
    endtask

    task automatic send_bit(input logic v);
        line = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        fall_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         gap_bits;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0, busy_cycles, lat, n_exp, n_got;
        logic [7:0] exp_q[$];
        int exp_ferr;

        vecs[0] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
        vecs[1] = '{8'hFF, 1'b1, 1, 1, 0, 8'hFF};
        vecs[2] = '{8'hA5, 1'b0, 1, 0, 1, 8'hFF};
        vecs[3] = '{8'h3C, 1'b1, 0, 1, 0, 8'h3C};
        vecs[4] = '{8'h01, 1'b1, 2, 1, 0, 8'h01};
        vecs[5] = '{8'h80, 1'b0, 1, 0, 1, 8'h01};
        vecs[6] = '{8'h7E, 1'b1, 1, 1, 0, 8'h7E};

        // Reset values
        repeat (4) @(negedge clk);
        check("reset_data", data, 8'h00);
        check("reset_valid", valid, 1'b0);
        check("reset_ferr", frame_err, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_no_valid", valid_cnt, 0);

        // Single 0x55 frame
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b1);
        lat = last_valid_cyc - fall_cyc;
        send_bit(1'b1);
        check("f55_valid_count", valid_cnt - v0, 1);
        check("f55_ferr_count", ferr_cnt - f0, 0);
        check("f55_data", data, 8'h55);
        check("f55_busy_idle", busy, 1'b0);
        check("f55_busy_low_at_valid", busy_at_valid, 1'b0);
        check_le("f55_latency", lat, LAT_MAX);

        // Directed table, including 0x00/0xFF back-to-back
        for (int i = 0; i < 7; i++) begin
            v0 = valid_cnt; f0 = ferr_cnt;
            send_frame(vecs[i].b, vecs[i].stop);
            check($sformatf("vec%0d_valid", i), valid_cnt - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
            for (int g = 0; g < vecs[i].gap_bits; g++) send_bit(1'b1);
        end
        send_bit(1'b1);

        // Glitch rejection
        v0 = valid_cnt; f0 = ferr_cnt; busy_cycles = 0;
        line = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        line = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        check_le("glitch_busy_cycles", busy_cycles, 10);
        check("glitch_busy_seen", busy_cycles > 0, 1'b1);
        check("glitch_valid", valid_cnt - v0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_busy_idle", busy, 1'b0);

        // Framing error followed by a held-low break
        send_frame(8'h55, 1'b1);
        send_bit(1'b1);
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b0);
        repeat (40) @(negedge clk);
        check("brk_ferr", ferr_cnt - f0, 1);
        check("brk_valid", valid_cnt - v0, 0);
        check("brk_data_kept", data, 8'h55);
        check("brk_busy_held", busy, 1'b1);
        line = 1'b1;
        repeat (5) @(negedge clk);
        check("brk_busy_released", busy, 1'b0);
        send_bit(1'b1);

        // Reset during the 4th data bit of 0x3C
        v0 = valid_cnt;
        send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        line = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mrst_data", data, 8'h00);
        check("mrst_valid", valid, 1'b0);
        check("mrst_ferr", frame_err, 1'b0);
        check("mrst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("mrst_no_valid", valid_cnt - v0, 0);
        send_frame(8'h3C, 1'b1);
        send_bit(1'b1);
        check("mrst_valid_after", valid_cnt - v0, 1);
        check("mrst_data_after", data, 8'h3C);

        // Loopback: incrementing 0..255 back-to-back, then random frames with random gaps and stop errors
        rx_q.delete();
        f0 = ferr_cnt;
        exp_ferr = 0;
        for (int i = 0; i < 256; i++) begin
            send_frame(8'(i), 1'b1);
            exp_q.push_back(8'(i));
        end
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            bit bad;
            int gap;
            b   = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            gap = bad ? 1 + $urandom_range(0, 2) : $urandom_range(0, 2);
            send_frame(b, !bad);
            if (bad) exp_ferr++;
            else     exp_q.push_back(b);
            for (int g = 0; g < gap; g++) send_bit(1'b1);
        end
        send_bit(1'b1);
        send_bit(1'b1);
        n_exp = exp_q.size();
        n_got = rx_q.size();
        check("lb_count", n_got, n_exp);
        check("lb_ferr", ferr_cnt - f0, exp_ferr);
        for (int i = 0; i < n_exp; i++) begin
            logic [8:0] got;
            got = (i < n_got) ? {1'b0, rx_q[i]} : 9'h1FF;
            check($sformatf("lb_byte%0d", i), got, {1'b0, exp_q[i]});
        end

        check("no_valid_ferr_overlap", overlap_seen, 1'b0);
        check("valid_one_cycle", long_valid, 1'b0);
        check("ferr_one_cycle", long_ferr, 1'b0);
        check("busy_low_at_valid", busy_at_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
